// File: rtl/encoder_req_conditioner.sv
// Request conditioner for the 8-to-3 encoder: sync, debounce, priority, handshake.
// Optional auto-repeat of a held request is built when AUTO_REPEAT_EN is defined.
module encoder_req_conditioner #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] onehot,
  output logic       multi
);

  if (STABLE_CYCLES == 0 ||
      STABLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be 1..2^CNT_W-1");
  end

  if (REPEAT_CYCLES == 0 ||
      REPEAT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESENT,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  state_t           state, state_n;
  logic [7:0]       sync1, s;
  logic [7:0]       cap, cap_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       last_oh, last_oh_n;
  logic             last_multi, last_multi_n;
  logic             valid_n, multi_n;
  logic [7:0]       onehot_n;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT = CNT_W'(REPEAT_CYCLES);
  logic [CNT_W-1:0] rep, rep_n;
`endif

  // Highest-index set bit wins.
  function automatic logic [7:0] top_bit(input logic [7:0] v);
    top_bit = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) top_bit = 8'(1) << i;
    end
  endfunction

  function automatic logic many(input logic [7:0] v);
    many = |(v & (v - 8'd1));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      s          <= '0;
      state      <= IDLE;
      cap        <= '0;
      cnt        <= '0;
      last_oh    <= '0;
      last_multi <= 1'b0;
      valid      <= 1'b0;
      onehot     <= '0;
      multi      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep        <= '0;
`endif
    end else begin
      sync1      <= req;
      s          <= sync1;
      state      <= state_n;
      cap        <= cap_n;
      cnt        <= cnt_n;
      last_oh    <= last_oh_n;
      last_multi <= last_multi_n;
      valid      <= valid_n;
      onehot     <= onehot_n;
      multi      <= multi_n;
`ifdef AUTO_REPEAT_EN
      rep        <= rep_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cap_n        = cap;
    cnt_n        = cnt;
    last_oh_n    = last_oh;
    last_multi_n = last_multi;
`ifdef AUTO_REPEAT_EN
    rep_n        = rep;
`endif
    unique case (state)
      IDLE: begin
        if (s != '0) begin
          cap_n   = s;
          cnt_n   = CNT_W'(1);
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s == '0) begin
          state_n = IDLE;
        end else if (s != cap) begin
          cap_n = s;
          cnt_n = CNT_W'(1);
        end else if (cnt == STABLE) begin
          state_n      = PRESENT;
          last_oh_n    = top_bit(cap);
          last_multi_n = many(cap);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (valid && ready) begin
          cnt_n   = '0;
          state_n = RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_n   = '0;
`endif
        end
      end
      RELEASE: begin
        if (s == '0) begin
          cnt_n = cnt + 1'b1;
          if (cnt == STABLE - 1'b1) state_n = IDLE;
        end else begin
          cnt_n = '0;
        end
`ifdef AUTO_REPEAT_EN
        // A held press re-arms itself after REPEAT_CYCLES matching samples.
        if (s == cap) begin
          rep_n = rep + 1'b1;
          if (rep_n == REPEAT) state_n = PRESENT;
        end else begin
          rep_n = '0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    valid_n  = (state_n == PRESENT);
    onehot_n = valid_n ? last_oh_n : '0;
    multi_n  = valid_n && last_multi_n;
  end

endmodule

// File: tb/tb_encoder_req_conditioner.sv
// Bench for encoder_req_conditioner: directed scenarios then random stimulus,
// all checked against a run-length reference model.
module tb_encoder_req_conditioner;

  localparam int STABLE = 4;
  localparam int REPEAT = 16;
  localparam int ARMED = 0;
  localparam int SHOWING = 1;
  localparam int RELEASING = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [7:0] onehot;
  logic       multi;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int dut_xfers = 0;
  int model_xfers = 0;

  logic [7:0] p1, p2, held, m_oh;
  logic       m_multi;
  int         phase, run, zeros, rep;

  encoder_req_conditioner #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(8),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ready(ready),
    .valid(valid),
    .onehot(onehot),
    .multi(multi)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] top_of(input logic [7:0] v);
    int k = $clog2(int'(v) + 1) - 1;
    return 8'(1) << k;
  endfunction

  // One clock edge of the reference: s lags req by two edges.
  task automatic model_edge();
    logic [7:0] sv;
    if (rst) begin
      p1 = '0; p2 = '0; held = '0;
      phase = ARMED; run = 0; zeros = 0; rep = 0;
      return;
    end
    sv = p2;
    p2 = p1;
    p1 = req;
    case (phase)
      ARMED: begin
        if (sv == 0) run = 0;
        else if (run > 0 && sv == held) run++;
        else begin held = sv; run = 1; end
        if (run == STABLE + 1) begin
          phase = SHOWING;
          m_oh = top_of(held);
          m_multi = ($countones(held) > 1);
        end
      end
      SHOWING: begin
        if (ready) begin
          phase = RELEASING; zeros = 0; rep = 0;
          model_xfers++;
        end
      end
      default: begin
        if (sv == 0) zeros++;
        else zeros = 0;
        if (zeros == STABLE) begin
          phase = ARMED; run = 0;
        end
`ifdef AUTO_REPEAT_EN
        if (sv == held) rep++;
        else rep = 0;
        if (rep == REPEAT) phase = SHOWING;
`endif
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    logic ev;
    if (valid && ready && !rst) dut_xfers++;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    ev = (phase == SHOWING);
    chk("valid", valid, ev);
    chk("onehot", onehot, ev ? m_oh : 8'h00);
    chk("multi", multi, ev && m_multi);
    chk("onehot_pop", $countones(onehot), ev);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, valid, 1);
  endtask

  task automatic idle(input int n);
    req = 8'h00;
    ready = 1'b1;
    repeat (n) tick();
  endtask

  int x0;
  logic [7:0] pats [4];
  logic [7:0] exps [4];

  initial begin
    rst = 1'b1; req = 8'h00; ready = 1'b1;
    p1 = '0; p2 = '0; held = '0; m_oh = '0; m_multi = 1'b0;
    phase = ARMED; run = 0; zeros = 0; rep = 0;

    // reset and single press from edge 10
    tick(); tick();
    chk("rst_valid", valid, 0);
    chk("rst_onehot", onehot, 8'h00);
    rst = 1'b0;
    repeat (8) tick();
    req = 8'h04;
    repeat (6) tick();
    chk("press_early", valid, 0);
    tick();
    chk("press_edge17", edge_n, 17);
    chk("press_valid", valid, 1);
    chk("press_onehot", onehot, 8'h04);
    chk("press_multi", multi, 0);
    tick();
    chk("press_drop", valid, 0);
    idle(20);
    chk("press_xfers", dut_xfers, 1);

    // bounce
    for (int i = 0; i < 3; i++) begin
      req = 8'h10;
      tick(); chk("bounce_quiet", valid, 0);
      tick(); chk("bounce_quiet", valid, 0);
      req = 8'h00;
      tick(); chk("bounce_quiet", valid, 0);
      tick(); chk("bounce_quiet", valid, 0);
    end
    req = 8'h10;
    repeat (STABLE + 2) tick();
    chk("bounce_early", valid, 0);
    tick();
    chk("bounce_valid", valid, 1);
    chk("bounce_onehot", onehot, 8'h10);
    tick();
    idle(12);

    // multi-hit
    pats[0] = 8'h81; exps[0] = 8'h80;
    pats[1] = 8'h06; exps[1] = 8'h04;
    for (int i = 0; i < 2; i++) begin
      req = pats[i];
      wait_valid("multi_wait");
      chk("multi_onehot", onehot, exps[i]);
      chk("multi_flag", multi, 1);
      tick();
      idle(12);
    end

    // backpressure
    ready = 1'b0;
    req = 8'h08;
    wait_valid("bp_wait");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) req = 8'h01;
      tick();
      chk("bp_hold", onehot, 8'h08);
    end
    x0 = dut_xfers;
    ready = 1'b1;
    tick();
    chk("bp_drop", valid, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("bp_no_repress", valid, 0);
    end
    chk("bp_one_xfer", dut_xfers - x0, 1);
    idle(12);
    req = 8'h01;
    wait_valid("bp_repress");
    chk("bp_repress_oh", onehot, 8'h01);
    tick();
    idle(12);

    // reset while presenting
    ready = 1'b0;
    req = 8'h20;
    wait_valid("rst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", valid, 0);
    chk("midrst_onehot", onehot, 8'h00);
    chk("midrst_multi", multi, 0);
    repeat (STABLE + 2) tick();
    chk("midrst_early", valid, 0);
    tick();
    chk("midrst_valid2", valid, 1);
    chk("midrst_onehot2", onehot, 8'h20);
    ready = 1'b1;
    tick();
    idle(12);

    // held request with ready high
    x0 = dut_xfers;
    req = 8'h02;
    repeat (60) tick();
    idle(30);
`ifdef AUTO_REPEAT_EN
    chk("hold_xfers", dut_xfers - x0, 4);
`else
    chk("hold_xfers", dut_xfers - x0, 1);
`endif

    // random
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(5))
          0: req = 8'h00;
          1: req = 8'h01;
          2: req = 8'h81;
          3: req = 8'h06;
          4: req = 8'hff;
          default: req = 8'($urandom);
        endcase
      end
      ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 1'b0;
    idle(12);
    chk("xfer_total", dut_xfers, model_xfers);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/encoder_req_conditioner.md
Name: encoder_req_conditioner

Overview:
- Upstream stage of the 8-to-3 encoder.
- Takes 8 raw, asynchronous request lines (switches/keys) and synchronises and debounces them.
- Resolves multiple simultaneous hits by fixed priority and presents a clean one-hot vector with a valid/ready handshake.
- Guarantees the encoder only ever sees all-zero or exactly one bit set.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a vector is accepted (legal 1..2^CNT_W-1).
- CNT_W, 8, width of the debounce/repeat counter.
- REPEAT_CYCLES, 16, hold time before auto-repeat re-presents a held request (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  raw asynchronous request lines; bit i corresponds to encoder input d_i.
- ready  input  1  downstream accepts onehot when high together with valid.
- valid  output  1  onehot holds a debounced request.
- onehot  output  8  exactly one bit set while valid=1; all zero otherwise.
- multi  output  1  captured vector had more than one bit set; qualified by valid.

Behaviour:
- Reset: rst sampled high at a clk edge forces state IDLE, clears both synchroniser stages, capture register and counter, and sets valid=0, onehot=0, multi=0. Reset mid-operation behaves identically, including mid-handshake; any pending request is dropped.
- Synchroniser: 2-flop per bit on req gives s[7:0]. No logic reads req directly.
- FSM states: IDLE, DEBOUNCE, PRESENT, RELEASE.
- IDLE: valid=0. When s!=0, capture cap<=s, cnt<=1, go to DEBOUNCE.
- DEBOUNCE, per edge:
  - s==0: go to IDLE.
  - s!=cap: cap<=s, cnt<=1.
  - s==cap and cnt==STABLE_CYCLES: go to PRESENT; onehot<=highest-index set bit of cap (bit 7 wins); multi<=(popcount(cap)>1); valid<=1.
  - Otherwise cnt<=cnt+1.
- Latency: req held constant from edge N gives valid=1 after edge N+STABLE_CYCLES+3, i.e. N+7 at default.
- PRESENT:
  - valid, onehot and multi are held stable; req activity is ignored.
  - Transfer occurs at an edge with valid&ready=1. Next cycle: valid=0, onehot=0, multi=0, cnt<=0, go to RELEASE.
  - ready while valid=0 has no effect.
  - No timeout; valid may stay high indefinitely.
- RELEASE:
  - s==0 increments cnt; any s!=0 clears cnt.
  - cnt reaching STABLE_CYCLES goes to IDLE.
  - No new request is presented until a full debounced release.
- Outputs are registered; no combinational path from ready or req to any output.
- Counter never wraps: it saturates at compare value. STABLE_CYCLES=0 is illegal; flag it with an elaboration-time check.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In RELEASE, if s==cap, a separate repeat counter counts consecutive cycles.
  - On reaching REPEAT_CYCLES, go to PRESENT with the same onehot/multi as the last transfer and valid=1.
  - Any s!=cap clears the repeat counter; release proceeds as normal.
- Undefined:
  - No repeat logic is generated.
  - A held request produces exactly one transfer until released.

Test Plan:
- Single press:
  - Stimulus: rst 2 cycles; req=8'h04 from edge 10; ready=1.
  - Required: valid=1 after edge 17 with onehot=8'h04, multi=0; valid=0 the next cycle; exactly one transfer.
- Bounce:
  - Stimulus: req toggles 8'h10/8'h00 every 2 cycles for 12 cycles, then holds 8'h10.
  - Required: no valid during toggling; valid with onehot=8'h10 STABLE_CYCLES+3 edges after the final change.
- Multi-hit:
  - Stimulus: req=8'h81 held.
  - Required: onehot=8'h80, multi=1.
  - Stimulus: req=8'h06 held.
  - Required: onehot=8'h04, multi=1.
- Backpressure:
  - Stimulus: ready=0 for 20 cycles after valid rises; change req to 8'h01 meanwhile; then ready=1.
  - Required: onehot stays at the original value throughout, then one transfer. 8'h01 is not presented until req is released and re-pressed.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while in PRESENT.
  - Required: valid=0, onehot=0, multi=0 on the next cycle. With req still held, a fresh debounce gives valid after STABLE_CYCLES+3 edges.
- AUTO_REPEAT_EN:
  - Stimulus: hold req=8'h02 with ready=1.
  - Required: transfers every REPEAT_CYCLES+1 cycles while held; none after release.
  - Without the macro: exactly one transfer.
